// File: rtl/reg4_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg4_arb_pkg
// Shared definitions for the round-robin shared-register arbiter:
//   - arb_state_t : FSM state encoding (IDLE, GRANT)
//   - DATA_W      : width of the shared register and of each write lane
//   - MAX_REQ     : largest supported requester count
//   - IDX_W       : width of a requester index (enough for MAX_REQ)
//   - wrap_inc()  : index increment that wraps modulo the live requester count
// -----------------------------------------------------------------------------
package reg4_arb_pkg;

    localparam int DATA_W  = 4;
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Next index after idx, wrapping back to 0 past the last live requester.
    // n_req is not a power of two in general, so a plain +1 is not enough.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input int               n_req);
        if (int'(idx) >= n_req - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/reg4_rr_pick.sv
// -----------------------------------------------------------------------------
// reg4_rr_pick
// Purely combinational round-robin winner selection. The search starts at
// index ptr and wraps modulo N_REQ; the first requester found with its req bit
// high wins.
//
// Parameters:
//   N_REQ : number of live requesters (2..MAX_REQ)
// Ports:
//   req   [N_REQ-1:0] in  : request bits
//   ptr   [IDX_W-1:0] in  : search start index (always < N_REQ)
//   valid             out : at least one request is pending
//   idx   [IDX_W-1:0] out : winning requester index (0 when valid is low)
// -----------------------------------------------------------------------------
module reg4_rr_pick
    import reg4_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam int SUM_W = IDX_W + 1;

    // Request vector widened to MAX_REQ so that indexing by a full IDX_W-bit
    // value is always in range, whatever N_REQ is.
    logic [MAX_REQ-1:0] req_pad;
    // cand[k] is the requester examined at search offset k from ptr.
    logic [IDX_W-1:0]   cand [MAX_REQ];
    logic [MAX_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_pad
            if (gi < N_REQ) begin : g_live
                assign req_pad[gi] = req[gi];
            end else begin : g_dead
                assign req_pad[gi] = 1'b0;
            end
        end

        for (gi = 0; gi < MAX_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            // ptr < N_REQ and gi < N_REQ, so sum < 2*N_REQ and a single
            // conditional subtract is a complete modulo.
            assign sum = {1'b0, ptr} + SUM_W'(gi);
            assign cand[gi] = (sum >= SUM_W'(N_REQ)) ? IDX_W'(sum - SUM_W'(N_REQ))
                                                     : sum[IDX_W-1:0];
            if (gi < N_REQ) begin : g_live
                assign hit[gi] = req_pad[cand[gi]];
            end else begin : g_dead
                assign hit[gi] = 1'b0;
            end
        end
    endgenerate

    // Scan from the farthest offset down to offset 0 so that the nearest hit
    // to ptr is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/reg4_arbiter.sv
// -----------------------------------------------------------------------------
// reg4_arbiter
// Round-robin arbiter guarding one shared 4-bit register. In IDLE the
// round-robin winner is latched into gnt_id and the FSM moves to GRANT. In
// GRANT, if the granted requester still asserts req, ack is strobed for that
// cycle and q loads the requester's data lane at the closing edge; the
// round-robin pointer then moves past the winner. If req has dropped, the
// write is aborted silently. Every grant returns to IDLE, so one write takes
// two cycles.
//
// Optional feature (compile-time macro REG4_ARB_CLR_EN):
//   adds input clr; clr high in IDLE clears q, stays in IDLE, leaves ptr
//   alone and takes priority over pending requests. clr in GRANT is ignored.
//   Without the macro the port and its logic do not exist.
//
// Parameters:
//   N_REQ : number of requesters, 2..4
// Ports:
//   clk                    in  : clock, rising edge
//   R                      in  : asynchronous active-high reset
//   req   [N_REQ-1:0]      in  : write request per requester
//   wdata [4*N_REQ-1:0]    in  : write data, requester i on [4i+3:4i]
//   clr                    in  : synchronous clear of q (REG4_ARB_CLR_EN only)
//   ack   [N_REQ-1:0]      out : one-hot write-done strobe
//   q     [3:0]            out : shared register contents
//   busy                   out : high while in GRANT
//   gnt_id [1:0]           out : current or last granted requester
// -----------------------------------------------------------------------------
module reg4_arbiter
    import reg4_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    clk,
    input  logic                    R,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] wdata,
`ifdef REG4_ARB_CLR_EN
    input  logic                    clr,
`endif
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       q,
    output logic                    busy,
    output logic [IDX_W-1:0]        gnt_id
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t        state_reg,  state_next;
    logic [IDX_W-1:0]  gnt_id_reg, gnt_id_next;
    logic [IDX_W-1:0]  ptr_reg,    ptr_next;
    logic [DATA_W-1:0] q_reg,      q_next;

    // -------------------------------------------------------------------------
    // Per-requester views widened to MAX_REQ, so gnt_id_reg can index them
    // directly without range concerns for smaller N_REQ.
    // -------------------------------------------------------------------------
    logic [MAX_REQ-1:0] req_pad;
    logic [DATA_W-1:0]  wdata_lane [MAX_REQ];
    logic [MAX_REQ-1:0] ack_pad;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_lane
            if (gi < N_REQ) begin : g_live
                assign req_pad[gi]    = req[gi];
                assign wdata_lane[gi] = wdata[gi*DATA_W +: DATA_W];
            end else begin : g_dead
                assign req_pad[gi]    = 1'b0;
                assign wdata_lane[gi] = '0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin winner search
    // -------------------------------------------------------------------------
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    reg4_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // -------------------------------------------------------------------------
    // State registers (FSM, grant index, round-robin pointer)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_reg  <= IDLE;
            gnt_id_reg <= '0;
            ptr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_id_reg <= gnt_id_next;
            ptr_reg    <= ptr_next;
        end
    end

    // Shared register storage.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        gnt_id_next = gnt_id_reg;
        ptr_next    = ptr_reg;
        q_next      = q_reg;
        ack_pad     = '0;

        case (state_reg)
            IDLE: begin
`ifdef REG4_ARB_CLR_EN
                // Clear wins over requests; they are picked up next cycle
                // because req is held until ack.
                if (clr) begin
                    q_next = '0;
                end else
`endif
                if (pick_valid) begin
                    gnt_id_next = pick_idx;
                    state_next  = GRANT;
                end
            end

            GRANT: begin
                // Every grant lasts exactly one cycle; requests that arrive
                // now are only looked at once back in IDLE.
                state_next = IDLE;
                if (req_pad[gnt_id_reg]) begin
                    ack_pad[gnt_id_reg] = 1'b1;
                    q_next              = wdata_lane[gnt_id_reg];
                    ptr_next            = wrap_inc(gnt_id_reg, N_REQ);
                end
                // Otherwise the requester withdrew: abort with q and ptr
                // untouched.
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ack    = ack_pad[N_REQ-1:0];
    assign q      = q_reg;
    assign busy   = (state_reg == GRANT);
    assign gnt_id = gnt_id_reg;

endmodule

// File: tb/tb_reg4_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg4_arbiter
// Self-checking bench for reg4_arbiter (N_REQ = 4). Expected writes are pushed
// to a scoreboard queue as requests are driven and popped when ack appears.
// Build with REG4_ARB_CLR_EN defined to also exercise the clr feature.
// -----------------------------------------------------------------------------
module tb_reg4_arbiter;

    logic        clk = 1'b0;
    logic        R   = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] wdata = 16'h0000;
`ifdef REG4_ARB_CLR_EN
    logic        clr = 1'b0;
`endif
    logic [3:0]  ack;
    logic [3:0]  q;
    logic        busy;
    logic [1:0]  gnt_id;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];

    reg4_arbiter #(
        .N_REQ (4)
    ) dut (
        .clk    (clk),
        .R      (R),
        .req    (req),
        .wdata  (wdata),
`ifdef REG4_ARB_CLR_EN
        .clr    (clr),
`endif
        .ack    (ack),
        .q      (q),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [3:0] d);
        wdata[i*4 +: 4] = d;
    endtask

    task automatic pulse_reset;
        R = 1'b1;
        #2;
        R = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        R   = 1'b1;
        req = 4'b0000;
        tick;
        tests_run++; if (q !== 4'h0) begin tests_failed++; $display("FAIL reset_q: got %h expected 0", q); end
        tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (gnt_id !== 2'd0) begin tests_failed++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
        tests_run++; if (dut.ptr_reg !== 2'd0) begin tests_failed++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_reg); end
        R = 1'b0;
        tick;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
        $display("[TB] reset: q=%h ack=%b busy=%b", q, ack, busy);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single;
        exp_t e;
        int   cyc;
        set_lane(0, 4'hA);
        req = 4'b0001;
        sb.push_back('{id: 0, data: 4'hA});
        cyc = 0;
        @(negedge clk);
        while (ack === 4'b0000 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (ack === 4'b0000) begin
            tests_run++; tests_failed++;
            $display("FAIL single_timeout: got no ack, required ack within 8 cycles");
        end else begin
            e = sb.pop_front();
            tests_run++; if (ack !== (4'b0001 << e.id)) begin tests_failed++; $display("FAIL single_ack: got %b expected %b", ack, 4'b0001 << e.id); end
            tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL single_latency: ack at cycle %0d expected 1", cyc); end
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy); end
            tests_run++; if (q !== 4'h0) begin tests_failed++; $display("FAIL single_q_early: got %h expected 0", q); end
            tick;
            req = 4'b0000;
            tests_run++; if (q !== e.data) begin tests_failed++; $display("FAIL single_q: got %h expected %h", q, e.data); end
            tests_run++; if (dut.ptr_reg !== 2'd1) begin tests_failed++; $display("FAIL single_ptr: got %0d expected 1", dut.ptr_reg); end
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: busy got %b expected 0", busy); end
        end
        $display("[TB] single: q=%h ptr=%0d", q, dut.ptr_reg);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_abort;
        set_lane(2, 4'h5);
        req = 4'b0100;
        tick;
        req = 4'b0000;
        @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_busy: got %b expected 1", busy); end
        tests_run++; if (gnt_id !== 2'd2) begin tests_failed++; $display("FAIL abort_gnt: got %0d expected 2", gnt_id); end
        tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL abort_ack: got %b expected 0000", ack); end
        tick;
        tests_run++; if (q !== 4'hA) begin tests_failed++; $display("FAIL abort_q: got %h expected a", q); end
        tests_run++; if (dut.ptr_reg !== 2'd1) begin tests_failed++; $display("FAIL abort_ptr: got %0d expected 1", dut.ptr_reg); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
        $display("[TB] abort: q=%h ptr=%0d", q, dut.ptr_reg);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midop;
        exp_t e;
        int   cyc;
        set_lane(1, 4'hF);
        req = 4'b0010;
        tick;
        #1;
        R = 1'b1;
        #1;
        tests_run++; if (q !== 4'h0) begin tests_failed++; $display("FAIL midrst_q: got %h expected 0", q); end
        tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL midrst_ack: got %b expected 0000", ack); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests_run++; if (gnt_id !== 2'd0) begin tests_failed++; $display("FAIL midrst_gnt: got %0d expected 0", gnt_id); end
        #1;
        R = 1'b0;
        sb.push_back('{id: 1, data: 4'hF});
        cyc = 0;
        @(negedge clk);
        while (ack === 4'b0000 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (ack === 4'b0000) begin
            tests_run++; tests_failed++;
            $display("FAIL midrst_timeout: got no ack, required ack within 8 cycles");
        end else begin
            e = sb.pop_front();
            tests_run++; if (ack !== (4'b0001 << e.id)) begin tests_failed++; $display("FAIL midrst_ack2: got %b expected %b", ack, 4'b0001 << e.id); end
            tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL midrst_latency: ack at cycle %0d expected 1", cyc); end
            tick;
            req = 4'b0000;
            tests_run++; if (q !== e.data) begin tests_failed++; $display("FAIL midrst_q2: got %h expected %h", q, e.data); end
            tests_run++; if (dut.ptr_reg !== 2'd2) begin tests_failed++; $display("FAIL midrst_ptr: got %0d expected 2", dut.ptr_reg); end
        end
        $display("[TB] reset_midop: q=%h ptr=%0d", q, dut.ptr_reg);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_contention;
        exp_t e;
        int   got;
        int   cyc;
        int   extra;
        pulse_reset;
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 4'(i + 1));
            sb.push_back('{id: i, data: 4'(i + 1)});
        end
        req = 4'b1111;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                e = sb.pop_front();
                tests_run++; if (ack !== (4'b0001 << e.id)) begin tests_failed++; $display("FAIL contend_ack%0d: got %b expected %b", got, ack, 4'b0001 << e.id); end
                tick;
                req[e.id] = 1'b0;
                tests_run++; if (q !== e.data) begin tests_failed++; $display("FAIL contend_q%0d: got %h expected %h", got, q, e.data); end
                $display("[TB] contention: ack id=%0d q=%h", e.id, q);
                got++;
            end else begin
                tick;
            end
            cyc++;
        end
        if (got < 4) begin
            tests_run++; tests_failed++;
            $display("FAIL contend_timeout: got %0d acks, required 4", got);
        end
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack !== 4'b0000) extra++;
            tick;
        end
        tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL contend_double_ack: got %0d extra acks expected 0", extra); end
        tests_run++; if (q !== 4'h4) begin tests_failed++; $display("FAIL contend_final_q: got %h expected 4", q); end
        tests_run++; if (dut.ptr_reg !== 2'd0) begin tests_failed++; $display("FAIL contend_ptr: got %0d expected 0", dut.ptr_reg); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wrap;
        exp_t e;
        int   got;
        int   cyc;
        pulse_reset;
        set_lane(2, 4'h8);
        req = 4'b0100;
        tick;
        tick;
        req = 4'b0000;
        tests_run++; if (dut.ptr_reg !== 2'd3) begin tests_failed++; $display("FAIL wrap_ptr_setup: got %0d expected 3", dut.ptr_reg); end
        tests_run++; if (q !== 4'h8) begin tests_failed++; $display("FAIL wrap_q_setup: got %h expected 8", q); end
        set_lane(3, 4'hC);
        set_lane(0, 4'h3);
        sb.push_back('{id: 3, data: 4'hC});
        sb.push_back('{id: 0, data: 4'h3});
        req = 4'b1001;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 20) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                e = sb.pop_front();
                tests_run++; if (ack !== (4'b0001 << e.id)) begin tests_failed++; $display("FAIL wrap_ack%0d: got %b expected %b", got, ack, 4'b0001 << e.id); end
                tick;
                req[e.id] = 1'b0;
                tests_run++; if (q !== e.data) begin tests_failed++; $display("FAIL wrap_q%0d: got %h expected %h", got, q, e.data); end
                $display("[TB] wrap: ack id=%0d q=%h", e.id, q);
                got++;
            end else begin
                tick;
            end
            cyc++;
        end
        if (got < 2) begin
            tests_run++; tests_failed++;
            $display("FAIL wrap_timeout: got %0d acks, required 2", got);
        end
        tests_run++; if (dut.ptr_reg !== 2'd1) begin tests_failed++; $display("FAIL wrap_ptr: got %0d expected 1", dut.ptr_reg); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back;
        logic [4:0] pattern;
        logic [3:0] want;
        pattern = 5'b01010;
        set_lane(0, 4'h6);
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            want = pattern[k] ? 4'b0001 : 4'b0000;
            tests_run++; if (ack !== want) begin tests_failed++; $display("FAIL b2b_ack_c%0d: got %b expected %b", k, ack, want); end
            $display("[TB] back_to_back: cycle %0d ack=%b", k, ack);
            tick;
        end
        req = 4'b0000;
        tick;
        tick;
        tests_run++; if (q !== 4'h6) begin tests_failed++; $display("FAIL b2b_q: got %h expected 6", q); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
    endtask

`ifdef REG4_ARB_CLR_EN
    // -------------------------------------------------------------------------
    task automatic test_clr;
        exp_t e;
        int   cyc;
        set_lane(0, 4'h7);
        req = 4'b0001;
        tick;
        tick;
        req = 4'b0000;
        tests_run++; if (q !== 4'h7) begin tests_failed++; $display("FAIL clr_setup_q: got %h expected 7", q); end
        // ptr is 1 after requester 0 was served
        set_lane(1, 4'h9);
        clr = 1'b1;
        req = 4'b0010;
        sb.push_back('{id: 1, data: 4'h9});
        tick;
        clr = 1'b0;
        tests_run++; if (q !== 4'h0) begin tests_failed++; $display("FAIL clr_q: got %h expected 0", q); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL clr_busy: got %b expected 0", busy); end
        tests_run++; if (dut.ptr_reg !== 2'd1) begin tests_failed++; $display("FAIL clr_ptr: got %0d expected 1", dut.ptr_reg); end
        cyc = 0;
        @(negedge clk);
        while (ack === 4'b0000 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (ack === 4'b0000) begin
            tests_run++; tests_failed++;
            $display("FAIL clr_timeout: got no ack, required ack within 8 cycles");
        end else begin
            e = sb.pop_front();
            tests_run++; if (ack !== (4'b0001 << e.id)) begin tests_failed++; $display("FAIL clr_ack: got %b expected %b", ack, 4'b0001 << e.id); end
            tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL clr_latency: ack at cycle %0d expected 1", cyc); end
            tick;
            req = 4'b0000;
            tests_run++; if (q !== e.data) begin tests_failed++; $display("FAIL clr_q_after: got %h expected %h", q, e.data); end
        end
        $display("[TB] clr: q=%h", q);
        // clr while in GRANT must not disturb the write
        set_lane(2, 4'hB);
        req = 4'b0100;
        tick;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        req = 4'b0000;
        tests_run++; if (q !== 4'hB) begin tests_failed++; $display("FAIL clr_in_grant: got %h expected b", q); end
        $display("[TB] clr_in_grant: q=%h", q);
    endtask
`endif

    // -------------------------------------------------------------------------
    initial begin
        test_reset;
        test_single;
        test_abort;
        test_reset_midop;
        test_contention;
        test_wrap;
        test_back_to_back;
`ifdef REG4_ARB_CLR_EN
        test_clr;
`endif
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
